// File: rtl/tlc_chain_rx.sv
// Receive-side model of a TLC5940 daisy chain: samples the LED bus, latches GS/DC frames, runs the PWM counter.
// Pin edges act SYNC_STAGES+1 clocks after the pin; readback outputs are registered one clock after address/state.
module tlc_chain_rx #(
   parameter int CHIPS       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        led_sclk,
   input  logic        led_sin,
   input  logic        led_xlat,
   input  logic        led_mode,
   input  logic        led_blank,
   input  logic        led_gsclk,
   input  logic [5:0]  rd_addr,
   output logic [11:0] rd_gs,
   output logic [5:0]  rd_dc,
   output logic        rd_on,
   output logic [11:0] gs_count,
   output logic [9:0]  bit_count,
   output logic        gs_valid,
   output logic        dc_valid,
   output logic        len_error
);

   localparam int GS_BITS = CHIPS * 192;
   localparam int DC_BITS = CHIPS * 96;
   localparam int CHANS   = CHIPS * 16;
   localparam logic [9:0] GS_LEN = 10'(GS_BITS);
   localparam logic [9:0] DC_LEN = 10'(DC_BITS);

   // Pin order inside the synchroniser vector
   localparam int P_SCLK  = 0;
   localparam int P_SIN   = 1;
   localparam int P_XLAT  = 2;
   localparam int P_MODE  = 3;
   localparam int P_BLANK = 4;
   localparam int P_GSCLK = 5;

   logic [5:0] pins;
   logic [5:0] sync_q [SYNC_STAGES];
   logic [5:0] sync_s;
   logic [2:0] hist_q;
   logic       sclk_rise, xlat_rise, gsclk_rise;
   logic       sin_s, mode_s, blank_s;

   assign pins   = {led_gsclk, led_blank, led_mode, led_xlat, led_sin, led_sclk};
   assign sync_s = sync_q[SYNC_STAGES-1];

   // Only the edge-detected pins need a history flop; sin/mode/blank are used as levels
   assign sclk_rise  = sync_s[P_SCLK]  & ~hist_q[0];
   assign xlat_rise  = sync_s[P_XLAT]  & ~hist_q[1];
   assign gsclk_rise = sync_s[P_GSCLK] & ~hist_q[2];
   assign sin_s      = sync_s[P_SIN];
   assign mode_s     = sync_s[P_MODE];
   assign blank_s    = sync_s[P_BLANK];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         hist_q <= {sync_s[P_GSCLK], sync_s[P_XLAT], sync_s[P_SCLK]};
      end
   end

   logic [GS_BITS-1:0] shreg_q, shreg_d;
   logic [GS_BITS-1:0] gs_latch_q, gs_latch_d;
   logic [DC_BITS-1:0] dc_latch_q, dc_latch_d;
   logic [9:0]         bit_count_q, bit_count_d;
   logic [11:0]        gs_count_q, gs_count_d;
   logic               gs_valid_q, gs_valid_d;
   logic               dc_valid_q, dc_valid_d;
   logic               len_error_q, len_error_d;
   logic [11:0]        rd_gs_q, rd_gs_d;
   logic [5:0]         rd_dc_q, rd_dc_d;
   logic               rd_on_q, rd_on_d;

   // A coincident sclk rise is applied before the xlat compare and capture
   always_comb begin
      shreg_d     = shreg_q;
      gs_latch_d  = gs_latch_q;
      dc_latch_d  = dc_latch_q;
      bit_count_d = bit_count_q;
      gs_valid_d  = 1'b0;
      dc_valid_d  = 1'b0;
      len_error_d = 1'b0;
      if (sclk_rise) begin
         shreg_d = {shreg_q[GS_BITS-2:0], sin_s};
         if (bit_count_q != 10'h3FF) bit_count_d = bit_count_q + 10'd1;
      end
      if (xlat_rise) begin
         if (!mode_s && bit_count_d == GS_LEN) begin
            gs_latch_d = shreg_d;
            gs_valid_d = 1'b1;
         end else if (mode_s && bit_count_d == DC_LEN) begin
            dc_latch_d = shreg_d[DC_BITS-1:0];
            dc_valid_d = 1'b1;
         end else begin
            len_error_d = 1'b1;
         end
         bit_count_d = '0;
      end
   end

   always_comb begin
      gs_count_d = gs_count_q;
      if (blank_s) gs_count_d = '0;
      else if (gsclk_rise && gs_count_q != 12'hFFF) gs_count_d = gs_count_q + 12'd1;
   end

   // Out-of-range addresses fall through with zero
   always_comb begin
      rd_gs_d = '0;
      rd_dc_d = '0;
      for (int k = 0; k < CHANS; k++) begin
         if (rd_addr == 6'(k)) begin
            rd_gs_d = gs_latch_q[12*k +: 12];
            rd_dc_d = dc_latch_q[6*k +: 6];
         end
      end
      rd_on_d = !blank_s && (gs_count_q < rd_gs_d);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_q     <= '0;
         gs_latch_q  <= '0;
         dc_latch_q  <= '0;
         bit_count_q <= '0;
         gs_count_q  <= '0;
         gs_valid_q  <= 1'b0;
         dc_valid_q  <= 1'b0;
         len_error_q <= 1'b0;
         rd_gs_q     <= '0;
         rd_dc_q     <= '0;
         rd_on_q     <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         gs_latch_q  <= gs_latch_d;
         dc_latch_q  <= dc_latch_d;
         bit_count_q <= bit_count_d;
         gs_count_q  <= gs_count_d;
         gs_valid_q  <= gs_valid_d;
         dc_valid_q  <= dc_valid_d;
         len_error_q <= len_error_d;
         rd_gs_q     <= rd_gs_d;
         rd_dc_q     <= rd_dc_d;
         rd_on_q     <= rd_on_d;
      end
   end

   assign rd_gs     = rd_gs_q;
   assign rd_dc     = rd_dc_q;
   assign rd_on     = rd_on_q;
   assign gs_count  = gs_count_q;
   assign bit_count = bit_count_q;
   assign gs_valid  = gs_valid_q;
   assign dc_valid  = dc_valid_q;
   assign len_error = len_error_q;

endmodule
